logic_op_sequencer: RTL
=======================

// Module: logic_op_sequencer
// PURPOSE
//  Two-requester front end for the 8-bit logical unit (AND/OR/NOT/NAND/NOR/XOR).
//  Arbitrates requests and drives the unit's a/b/P/el inputs for a fixed settle window.
//  Captures the one result bus that matches the opcode.
//  Returns the result to the winning requester over a valid/ready response channel.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles lu_el is held low before capture; legal range 1..15
//  FAIR           1  1 = round-robin arbitration; 0 = fixed priority, req0 wins
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  req0_valid   in   1  requester 0 has an operation
//  req0_ready   out  1  requester 0 operation accepted this cycle
//  req0_op      in   3  requester 0 opcode (unit P encoding)
//  req0_a       in   8  requester 0 operand a
//  req0_b       in   8  requester 0 operand b
//  req1_*       -    -  same five signals for requester 1
//  resp_valid   out  1  response available
//  resp_ready   in   1  response consumer accepts
//  resp_id      out  1  index of the requester this response belongs to
//  resp_data    out  8  operation result
//  resp_err     out  1  opcode was not a legal operation
//  lu_a, lu_b   out  8  operands to the logical unit
//  lu_P         out  3  opcode to the logical unit
//  lu_el        out  1  logical unit enable, active low
//  lu_A..lu_F   in   8  unit result buses: AND, OR, NOT, NAND, NOR, XOR
// BEHAVIOUR
//  Reset values (asynchronous, while rst_n=0)
//   - state=IDLE; lu_el=1; lu_a=lu_b=0; lu_P=0.
//   - resp_valid=0; resp_data=0; resp_id=0; resp_err=0.
//   - last_grant=1, so req0 wins the first contention.
//   - req*_ready=0.
//  Opcode map
//   - 101 AND->lu_A; 110 OR->lu_B; 111 NOT->lu_C (a only); 000 NAND->lu_D;
//     001 NOR->lu_E; 010 XOR->lu_F.
//   - 011 and 100 are illegal.
//  FSM: IDLE, ISSUE, RESP
//   - IDLE: if any req*_valid, grant one requester.
//     - FAIR=1 and both valid: grant = ~last_grant.
//     - FAIR=0 and both valid: grant = 0.
//     - reqN_ready=1 combinationally for the granted requester only; the handshake completes that cycle.
//     - Latch op/a/b/id; update last_grant.
//     - Legal op -> ISSUE. Illegal op -> RESP with resp_err=1, resp_data=0; lu_el stays 1.
//   - ISSUE: lu_el=0; lu_a/lu_b/lu_P driven from the latched values.
//     - Settle counter runs 0..SETTLE_CYCLES-1.
//     - On the last count, register the selected lu_* bus into resp_data, set resp_err=0 -> RESP.
//     - lu_el returns to 1 on entry to RESP.
//     - Non-selected buses (high-Z) are never sampled.
//   - RESP: resp_valid=1; resp_data/id/err held stable until resp_ready=1.
//     - Then resp_valid=0 -> IDLE.
//     - No new grant in the same cycle; req*_ready=0 outside IDLE.
//  Latency
//   - Legal op: accept at edge 0, resp_valid high after edge SETTLE_CYCLES+1.
//   - Illegal op: resp_valid high after edge 1.
//   - Throughput: one operation in flight; at most one accept per SETTLE_CYCLES+2 cycles.
//  Boundaries
//   - Requester dropping valid before grant: no effect.
//   - Request held during RESP: waits, no loss.
//   - rst_n low mid-ISSUE or mid-RESP: operation aborted; lu_el=1 and resp_valid=0 immediately (asynchronous).
// TESTING
//  1. SETTLE=1: req0 AND a=F0 b=3C -> lu_el low 1 cycle, P=101; resp_valid 2 cycles after accept, data=30, id=0, err=0.
//  2. Both valid every cycle, FAIR=1: req0 XOR AA^55, req1 NOT 0F -> grants 0,1,0,1; data FF, F0 alternating.
//  3. Same stimulus, FAIR=0 -> req0 granted every time; req1 never ready.
//  4. req1 op=011 -> resp_err=1, data=00, id=1, lu_el never low, resp after 1 cycle.
//  5. resp_ready held low 5 cycles after NAND FF,FF -> resp_data=00 held stable; both req*_ready=0; NOR 00,00 then gives FF.
//  6. rst_n pulsed low in ISSUE -> lu_el=1 and resp_valid=0 with no clock edge; next contention grants req0.

Source files
------------

// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: two-requester arbiter/sequencer in front of an 8-bit logical unit
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_reqN_valid/op/a/b, o_reqN_ready  requester N operation channel (N = 0, 1)
//   o_resp_valid/id/data/err, i_resp_ready  response channel to the winning requester
//   o_lu_a/b/P/el                  operands, opcode and active-low enable to the unit
//   i_lu_A..i_lu_F                 unit result buses: AND, OR, NOT, NAND, NOR, XOR
module logic_op_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter bit FAIR          = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0_valid,
    output logic       o_req0_ready,
    input  logic [2:0] i_req0_op,
    input  logic [7:0] i_req0_a,
    input  logic [7:0] i_req0_b,
    input  logic       i_req1_valid,
    output logic       o_req1_ready,
    input  logic [2:0] i_req1_op,
    input  logic [7:0] i_req1_a,
    input  logic [7:0] i_req1_b,
    output logic       o_resp_valid,
    input  logic       i_resp_ready,
    output logic       o_resp_id,
    output logic [7:0] o_resp_data,
    output logic       o_resp_err,
    output logic [7:0] o_lu_a,
    output logic [7:0] o_lu_b,
    output logic [2:0] o_lu_P,
    output logic       o_lu_el,
    input  logic [7:0] i_lu_A,
    input  logic [7:0] i_lu_B,
    input  logic [7:0] i_lu_C,
    input  logic [7:0] i_lu_D,
    input  logic [7:0] i_lu_E,
    input  logic [7:0] i_lu_F
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t     r_state, w_next;
    logic       r_last_grant;
    logic [3:0] r_cnt;
    logic       w_any, w_grant, w_accept, w_legal, w_last_cnt;
    logic [2:0] w_op;
    logic [7:0] w_a, w_b, w_result;
    assign w_any        = i_req0_valid | i_req1_valid;
    // a lone requester always wins; contention resolved by policy
    assign w_grant      = (i_req0_valid & i_req1_valid) ? (FAIR ? ~r_last_grant : 1'b0) : i_req1_valid;
    assign w_accept     = (r_state == IDLE) & w_any;
    assign o_req0_ready = w_accept & ~w_grant;
    assign o_req1_ready = w_accept & w_grant;
    assign w_op         = w_grant ? i_req1_op : i_req0_op;
    assign w_a          = w_grant ? i_req1_a : i_req0_a;
    assign w_b          = w_grant ? i_req1_b : i_req0_b;
    assign w_legal      = (w_op != 3'b011) && (w_op != 3'b100);
    assign w_last_cnt   = r_cnt == 4'(SETTLE_CYCLES - 1);
    // enable and valid decode straight from state so an async reset clears them at once
    assign o_lu_el      = r_state != ISSUE;
    assign o_resp_valid = r_state == RESP;
    // only the bus matching the latched opcode is ever sampled
    always_comb begin
        w_result = i_lu_F;
        case (o_lu_P)
            3'b101:  w_result = i_lu_A;
            3'b110:  w_result = i_lu_B;
            3'b111:  w_result = i_lu_C;
            3'b000:  w_result = i_lu_D;
            3'b001:  w_result = i_lu_E;
            default: w_result = i_lu_F;
        endcase
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_legal ? ISSUE : RESP;
            ISSUE:   if (w_last_cnt) w_next = RESP;
            RESP:    if (i_resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            o_lu_a       <= '0;
            o_lu_b       <= '0;
            o_lu_P       <= '0;
            o_resp_id    <= 1'b0;
            o_resp_data  <= '0;
            o_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                o_lu_a       <= w_a;
                o_lu_b       <= w_b;
                o_lu_P       <= w_op;
                r_last_grant <= w_grant;
                o_resp_id    <= w_grant;
                r_cnt        <= '0;
                if (!w_legal) begin
                    o_resp_data <= '0;
                    o_resp_err  <= 1'b1;
                end
            end
            if (r_state == ISSUE) begin
                r_cnt <= r_cnt + 4'd1;
                if (w_last_cnt) begin
                    o_resp_data <= w_result;
                    o_resp_err  <= 1'b0;
                end
            end
        end
    end
endmodule
